mux_n1_scan: RTL and testbench

Parametrised N:1 multiplexer with a registered output and two select modes. In manual mode the select comes from an input port. In auto-scan mode an internal dwell counter steps through the channels round-robin. This is the successor to the combinational 8:1 mux in the lab datapath and feeds downstream sampling and display logic, which need a stable, registered channel value plus the channel index.

---
 rtl/mux_n1_scan.sv | 98 +++++++++
 tb/tb_mux_n1_scan.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_n1_scan.sv
// mux_n1_scan: N:1 multiplexer with a registered output and two select modes.
//   mode=0 : the channel is chosen by the s input.
//   mode=1 : an internal dwell counter steps through the channels round-robin.
//            Each channel is held for DWELL enabled cycles.
// Ports:
//   clk     - system clock; all state changes on its rising edge
//   rst_n   - synchronous active-low reset; overrides en and mode
//   i       - packed channel data; channel k is i[k*DW +: DW]
//   s       - manual channel select, used when mode=0
//   mode    - 0 = manual, 1 = auto-scan
//   en      - clock enable; 0 holds all state and forces wrap low
//   o       - registered data of the selected channel (0 if out of range)
//   sel_cur - registered index of the channel presented on o
//   valid   - sel_cur addresses a real channel
//   wrap    - one-cycle pulse when auto-scan steps from N_CH-1 to 0
module mux_n1_scan #(
    parameter int unsigned N_CH  = 8,
    parameter int unsigned DW    = 1,
    parameter int unsigned SELW  = 3,
    parameter int unsigned DWELL = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_CH*DW-1:0]   i,
    input  logic [SELW-1:0]      s,
    input  logic                 mode,
    input  logic                 en,
    output logic [DW-1:0]        o,
    output logic [SELW-1:0]      sel_cur,
    output logic                 valid,
    output logic                 wrap
);

    // Counter only needs to reach DWELL-1; keep at least one bit for DWELL=1.
    localparam int unsigned       CW        = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0]     DCNT_LAST = CW'(DWELL - 1);
    localparam logic [SELW-1:0]   SEL_LAST  = SELW'(N_CH - 1);

    logic [CW-1:0]   dcnt;
    logic [CW-1:0]   dcnt_nxt;
    logic [SELW-1:0] sel_nxt;
    logic            wrap_nxt;
    logic            valid_nxt;
    logic [DW-1:0]   o_nxt;

    always_comb begin
        sel_nxt  = sel_cur;
        dcnt_nxt = dcnt;
        wrap_nxt = 1'b0;
        if (!mode) begin
            sel_nxt  = s;
            dcnt_nxt = '0;
        end else if (dcnt != DCNT_LAST) begin
            dcnt_nxt = dcnt + 1'b1;
        end else begin
            dcnt_nxt = '0;
            if (sel_cur == SEL_LAST) begin
                sel_nxt  = '0;
                wrap_nxt = 1'b1;
            end else if (32'(sel_cur) >= N_CH) begin
                // Left over from an out-of-range manual select: restart at 0
                // without signalling a completed sweep.
                sel_nxt = '0;
            end else begin
                sel_nxt = sel_cur + 1'b1;
            end
        end
    end

    always_comb begin
        valid_nxt = (32'(sel_nxt) < N_CH);
        o_nxt     = '0;
        for (int k = 0; k < int'(N_CH); k++) begin
            if (sel_nxt == SELW'(k)) begin
                o_nxt = i[k*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o       <= '0;
            sel_cur <= '0;
            valid   <= 1'b0;
            wrap    <= 1'b0;
            dcnt    <= '0;
        end else if (en) begin
            o       <= o_nxt;
            sel_cur <= sel_nxt;
            valid   <= valid_nxt;
            wrap    <= wrap_nxt;
            dcnt    <= dcnt_nxt;
        end else begin
            wrap    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_n1_scan.sv
module tb_mux_n1_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: 8 channels x 1 bit, DWELL=4
    logic       rst_n_a = 1'b0;
    logic [7:0] i_a     = '0;
    logic [2:0] s_a     = '0;
    logic       mode_a  = 1'b0;
    logic       en_a    = 1'b1;
    logic [0:0] o_a;
    logic [2:0] sel_a;
    logic       valid_a;
    logic       wrap_a;

    // Instance B: 5 channels x 4 bits, DWELL=4
    logic        rst_n_b = 1'b0;
    logic [19:0] i_b     = 20'hEDCBA;
    logic [2:0]  s_b     = '0;
    logic        mode_b  = 1'b0;
    logic        en_b    = 1'b1;
    logic [3:0]  o_b;
    logic [2:0]  sel_b;
    logic        valid_b;
    logic        wrap_b;

    mux_n1_scan #(.N_CH(8), .DW(1), .SELW(3), .DWELL(4)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .i(i_a), .s(s_a), .mode(mode_a), .en(en_a),
        .o(o_a), .sel_cur(sel_a), .valid(valid_a), .wrap(wrap_a)
    );

    mux_n1_scan #(.N_CH(5), .DW(4), .SELW(3), .DWELL(4)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .i(i_b), .s(s_b), .mode(mode_b), .en(en_b),
        .o(o_b), .sel_cur(sel_b), .valid(valid_b), .wrap(wrap_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n_a = 1'b0; i_a = 8'hFF; mode_a = 1'b0; s_a = 3'd0; en_a = 1'b1;
        tick(); tick();
        total++;
        if ({o_a, sel_a, valid_a, wrap_a} !== 6'b0) begin
            bad++;
            $display("FAIL reset_state o=%0d sel=%0d valid=%0d wrap=%0d required all 0",
                     o_a, sel_a, valid_a, wrap_a);
        end
        rst_n_a = 1'b1;
        tick();
        total++;
        if (o_a !== 1'b1 || valid_a !== 1'b1) begin
            bad++;
            $display("FAIL reset_release o=%0d valid=%0d required o=1 valid=1", o_a, valid_a);
        end
    endtask

    task automatic test_manual();
        for (int k = 0; k < 8; k++) begin
            i_a = 8'(1 << k);
            s_a = 3'(k);
            tick();
            total++;
            if (o_a !== 1'b1 || sel_a !== 3'(k) || valid_a !== 1'b1 || wrap_a !== 1'b0) begin
                bad++;
                $display("FAIL manual_hit k=%0d o=%0d sel=%0d valid=%0d wrap=%0d required o=1 sel=%0d valid=1 wrap=0",
                         k, o_a, sel_a, valid_a, wrap_a, k);
            end
            s_a = 3'((k + 1) % 8);
            tick();
            total++;
            if (o_a !== 1'b0 || sel_a !== 3'((k + 1) % 8)) begin
                bad++;
                $display("FAIL manual_miss k=%0d o=%0d sel=%0d required o=0 sel=%0d",
                         k, o_a, sel_a, (k + 1) % 8);
            end
        end
    endtask

    // Auto-scan from reset, then an enable stall mid-dwell.
    task automatic test_auto_scan();
        int exp_sel;
        rst_n_a = 1'b0; tick();
        i_a = 8'b1010_1010; mode_a = 1'b1; rst_n_a = 1'b1;
        for (int n = 1; n <= 42; n++) begin
            tick();
            exp_sel = (n / 4) % 8;
            total++;
            if (sel_a !== 3'(exp_sel) || o_a !== 1'(exp_sel & 1) || valid_a !== 1'b1
                || wrap_a !== ((n % 32) == 0)) begin
                bad++;
                $display("FAIL auto_scan n=%0d sel=%0d o=%0d valid=%0d wrap=%0d required sel=%0d o=%0d valid=1 wrap=%0d",
                         n, sel_a, o_a, valid_a, wrap_a, exp_sel, exp_sel & 1, (n % 32) == 0);
            end
        end
    endtask

    task automatic test_enable_stall();
        int waited;
        // State now: sel=2 with two dwell cycles already spent.
        en_a = 1'b0;
        for (int n = 0; n < 5; n++) begin
            tick();
            total++;
            if (sel_a !== 3'd2 || o_a !== 1'b0 || wrap_a !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold n=%0d sel=%0d o=%0d wrap=%0d required sel=2 o=0 wrap=0",
                         n, sel_a, o_a, wrap_a);
            end
        end
        en_a = 1'b1;
        tick();
        total++;
        if (sel_a !== 3'd2) begin
            bad++;
            $display("FAIL stall_resume1 sel=%0d required 2", sel_a);
        end
        tick();
        total++;
        if (sel_a !== 3'd3 || o_a !== 1'b1) begin
            bad++;
            $display("FAIL stall_resume2 sel=%0d o=%0d required sel=3 o=1", sel_a, o_a);
        end
        // From sel=3, dcnt=0 the next wrap is 5*4 = 20 cycles away.
        waited = 0;
        while (wrap_a !== 1'b1 && waited < 40) begin
            tick();
            waited++;
        end
        total++;
        if (waited != 20) begin
            bad++;
            $display("FAIL wrap_spacing cycles=%0d required 20", waited);
        end
        // Dropping en right on the wrap pulse must clear it and hold sel.
        en_a = 1'b0;
        tick();
        total++;
        if (wrap_a !== 1'b0 || sel_a !== 3'd0) begin
            bad++;
            $display("FAIL stall_wrap wrap=%0d sel=%0d required wrap=0 sel=0", wrap_a, sel_a);
        end
        en_a = 1'b1;
    endtask

    task automatic test_mode_switch();
        mode_a = 1'b0; s_a = 3'd5;
        tick();
        total++;
        if (sel_a !== 3'd5 || o_a !== 1'b1) begin
            bad++;
            $display("FAIL mode_manual5 sel=%0d o=%0d required sel=5 o=1", sel_a, o_a);
        end
        mode_a = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            tick();
            total++;
            if (sel_a !== ((n < 4) ? 3'd5 : 3'd6) || wrap_a !== 1'b0) begin
                bad++;
                $display("FAIL mode_to_auto n=%0d sel=%0d wrap=%0d required sel=%0d wrap=0",
                         n, sel_a, wrap_a, (n < 4) ? 5 : 6);
            end
        end
        tick();
        mode_a = 1'b0; s_a = 3'd2;
        tick();
        total++;
        if (sel_a !== 3'd2 || o_a !== 1'b0 || valid_a !== 1'b1) begin
            bad++;
            $display("FAIL mode_to_manual sel=%0d o=%0d valid=%0d required sel=2 o=0 valid=1",
                     sel_a, o_a, valid_a);
        end
    endtask

    // 5 channels, 4-bit data: channel k holds 4'hA + k.
    task automatic test_nonpow2();
        int exp_sel;
        rst_n_b = 1'b0; tick();
        rst_n_b = 1'b1; mode_b = 1'b0; s_b = 3'd3;
        tick();
        total++;
        if (o_b !== 4'hD || valid_b !== 1'b1) begin
            bad++;
            $display("FAIL np_manual3 o=%0h valid=%0d required o=d valid=1", o_b, valid_b);
        end
        s_b = 3'd6;
        tick();
        total++;
        if (o_b !== 4'h0 || valid_b !== 1'b0 || sel_b !== 3'd6) begin
            bad++;
            $display("FAIL np_out_of_range o=%0h valid=%0d sel=%0d required o=0 valid=0 sel=6",
                     o_b, valid_b, sel_b);
        end
        mode_b = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            tick();
            total++;
            if (n < 4) begin
                if (sel_b !== 3'd6 || valid_b !== 1'b0) begin
                    bad++;
                    $display("FAIL np_recover_hold n=%0d sel=%0d valid=%0d required sel=6 valid=0",
                             n, sel_b, valid_b);
                end
            end else if (sel_b !== 3'd0 || valid_b !== 1'b1 || wrap_b !== 1'b0 || o_b !== 4'hA) begin
                bad++;
                $display("FAIL np_recover sel=%0d valid=%0d wrap=%0d o=%0h required sel=0 valid=1 wrap=0 o=a",
                         sel_b, valid_b, wrap_b, o_b);
            end
        end
        for (int m = 1; m <= 25; m++) begin
            tick();
            exp_sel = (m / 4) % 5;
            total++;
            if (sel_b !== 3'(exp_sel) || o_b !== 4'(10 + exp_sel) || wrap_b !== ((m % 20) == 0)) begin
                bad++;
                $display("FAIL np_scan m=%0d sel=%0d o=%0h wrap=%0d required sel=%0d o=%0h wrap=%0d",
                         m, sel_b, o_b, wrap_b, exp_sel, 10 + exp_sel, (m % 20) == 0);
            end
        end
        // Mid-scan reset (sel=1, dwell partly spent).
        rst_n_b = 1'b0;
        tick();
        total++;
        if (sel_b !== 3'd0 || o_b !== 4'h0 || valid_b !== 1'b0 || wrap_b !== 1'b0) begin
            bad++;
            $display("FAIL np_reset sel=%0d o=%0h valid=%0d wrap=%0d required all 0",
                     sel_b, o_b, valid_b, wrap_b);
        end
        rst_n_b = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            tick();
            total++;
            if (sel_b !== ((n < 4) ? 3'd0 : 3'd1) || o_b !== ((n < 4) ? 4'hA : 4'hB)) begin
                bad++;
                $display("FAIL np_after_reset n=%0d sel=%0d o=%0h required sel=%0d o=%0h",
                         n, sel_b, o_b, (n < 4) ? 0 : 1, (n < 4) ? 10 : 11);
            end
        end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_auto_scan();
        test_enable_stall();
        test_mode_switch();
        test_nonpow2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
